// File: rtl/index_collector.sv
// Collects a frame of bit indices (one per valid/ready beat) into a bitmap and
// publishes it with a population count and duplicate/out-of-range flags.
module index_collector #(
  parameter int unsigned OWIDTH = 16,
  parameter int unsigned IWIDTH = $clog2(OWIDTH),
  parameter int unsigned CWIDTH = $clog2(OWIDTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [IWIDTH-1:0] in_idx,
  input  logic              in_last,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [OWIDTH-1:0] out_map,
  output logic [CWIDTH-1:0] out_cnt,
  output logic              out_dup,
  output logic              out_oor
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [OWIDTH-1:0]   acc_map_q, acc_map_d;
  logic [CWIDTH-1:0]   acc_cnt_q, acc_cnt_d;
  logic                acc_dup_q, acc_dup_d;
  logic                acc_oor_q, acc_oor_d;
  logic [OWIDTH-1:0]   out_map_q, out_map_d;
  logic [CWIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic                out_dup_q, out_dup_d;
  logic                out_oor_q, out_oor_d;

  logic [OWIDTH-1:0]   nxt_map_c;
  logic [CWIDTH-1:0]   nxt_cnt_c;
  logic                nxt_dup_c;
  logic                nxt_oor_c;
  logic [OWIDTH-1:0]   idx_oh_c;
  logic                idx_oor_c;
  logic                in_fire_c;
  logic                last_fire_c;
  logic                out_fire_c;

  // An index can only fall outside the bitmap when OWIDTH is not a power of two.
  if (OWIDTH == (32'd1 << IWIDTH)) begin : g_pow2
    assign idx_oor_c = 1'b0;
  end else begin : g_npow2
    assign idx_oor_c = (32'(in_idx) >= OWIDTH);
  end

  assign idx_oh_c    = OWIDTH'(1) << in_idx;
  assign out_vld     = (state_q == FULL);
  assign in_rdy      = rst_n & ~clr & ~(out_vld & ~out_rdy);
  assign in_fire_c   = in_vld & in_rdy;
  assign last_fire_c = in_fire_c & in_last;
  assign out_fire_c  = out_vld & out_rdy;

  assign out_map = out_map_q;
  assign out_cnt = out_cnt_q;
  assign out_dup = out_dup_q;
  assign out_oor = out_oor_q;

  // Accumulator update, frame publication and output state.
  always_comb begin
    nxt_map_c = acc_map_q;
    nxt_cnt_c = acc_cnt_q;
    nxt_dup_c = acc_dup_q;
    nxt_oor_c = acc_oor_q;
    state_d   = state_q;
    out_map_d = out_map_q;
    out_cnt_d = out_cnt_q;
    out_dup_d = out_dup_q;
    out_oor_d = out_oor_q;

    if (in_fire_c) begin
      if (idx_oor_c) begin
        nxt_oor_c = 1'b1;
      end else if (|(acc_map_q & idx_oh_c)) begin
        nxt_dup_c = 1'b1;
      end else begin
        nxt_map_c = acc_map_q | idx_oh_c;
        nxt_cnt_c = acc_cnt_q + CWIDTH'(1);
      end
    end

    acc_map_d = nxt_map_c;
    acc_cnt_d = nxt_cnt_c;
    acc_dup_d = nxt_dup_c;
    acc_oor_d = nxt_oor_c;
    if (clr || last_fire_c) begin
      acc_map_d = '0;
      acc_cnt_d = '0;
      acc_dup_d = 1'b0;
      acc_oor_d = 1'b0;
    end

    // A new result takes priority over retiring the old one.
    if (last_fire_c) begin
      state_d   = FULL;
      out_map_d = nxt_map_c;
      out_cnt_d = nxt_cnt_c;
      out_dup_d = nxt_dup_c;
      out_oor_d = nxt_oor_c;
    end else if (out_fire_c) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      acc_map_q <= '0;
      acc_cnt_q <= '0;
      acc_dup_q <= 1'b0;
      acc_oor_q <= 1'b0;
      out_map_q <= '0;
      out_cnt_q <= '0;
      out_dup_q <= 1'b0;
      out_oor_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_map_q <= acc_map_d;
      acc_cnt_q <= acc_cnt_d;
      acc_dup_q <= acc_dup_d;
      acc_oor_q <= acc_oor_d;
      out_map_q <= out_map_d;
      out_cnt_q <= out_cnt_d;
      out_dup_q <= out_dup_d;
      out_oor_q <= out_oor_d;
    end
  end

endmodule

// File: tb/tb_index_collector.sv
// Drives a 16-wide and a 12-wide collector with identical beats and compares
// both against a frame-level reference model.
module tb_index_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_vld;
  logic [3:0]  in_idx;
  logic        in_last;
  logic        out_rdy;

  logic        rdy16, vld16, dup16, oor16;
  logic [15:0] map16;
  logic [4:0]  cnt16;
  logic        rdy12, vld12, dup12, oor12;
  logic [11:0] map12;
  logic [4:0]  cnt12;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 -> OWIDTH=16, index 1 -> OWIDTH=12.
  int          width [2] = '{16, 12};
  bit          seen  [2][16];
  bit          p_dup [2];
  bit          p_oor [2];
  bit          e_vld;
  logic [15:0] e_map [2];
  int          e_cnt [2];
  bit          e_dup [2];
  bit          e_oor [2];

  always #5 clk = ~clk;

  index_collector #(.OWIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(rdy16),
    .in_idx(in_idx), .in_last(in_last), .out_vld(vld16), .out_rdy(out_rdy),
    .out_map(map16), .out_cnt(cnt16), .out_dup(dup16), .out_oor(oor16)
  );

  index_collector #(.OWIDTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(rdy12),
    .in_idx(in_idx), .in_last(in_last), .out_vld(vld12), .out_rdy(out_rdy),
    .out_map(map12), .out_cnt(cnt12), .out_dup(dup12), .out_oor(oor12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_vld = 0;
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 16; b++) seen[m][b] = 0;
      p_dup[m] = 0; p_oor[m] = 0;
      e_map[m] = '0; e_cnt[m] = 0; e_dup[m] = 0; e_oor[m] = 0;
    end
  endtask

  task automatic check_outputs(input string tag, input bit data_too);
    chk({tag, ".vld16"}, 32'(vld16), 32'(e_vld));
    chk({tag, ".vld12"}, 32'(vld12), 32'(e_vld));
    if (data_too) begin
      chk({tag, ".map16"}, 32'(map16), 32'(e_map[0]));
      chk({tag, ".cnt16"}, 32'(cnt16), 32'(e_cnt[0]));
      chk({tag, ".dup16"}, 32'(dup16), 32'(e_dup[0]));
      chk({tag, ".oor16"}, 32'(oor16), 32'(e_oor[0]));
      chk({tag, ".map12"}, 32'(map12), 32'(e_map[1]));
      chk({tag, ".cnt12"}, 32'(cnt12), 32'(e_cnt[1]));
      chk({tag, ".dup12"}, 32'(dup12), 32'(e_dup[1]));
      chk({tag, ".oor12"}, 32'(oor12), 32'(e_oor[1]));
    end
  endtask

  // One clock cycle: drive, check ready, clock the model, check outputs.
  task automatic cycle(input string tag, input bit vld, input int idx, input bit last,
                       input bit ordy, input bit c);
    bit rdy_exp, fire;
    logic [15:0] fmap;
    in_vld = vld; in_idx = 4'(idx); in_last = last; out_rdy = ordy; clr = c;
    #1;
    rdy_exp = !c && !(e_vld && !ordy);
    chk({tag, ".rdy16"}, 32'(rdy16), 32'(rdy_exp));
    chk({tag, ".rdy12"}, 32'(rdy12), 32'(rdy_exp));
    fire = vld && rdy_exp;
    @(posedge clk);
    if (e_vld && ordy) e_vld = 0;
    for (int m = 0; m < 2; m++) begin
      if (fire) begin
        if (idx >= width[m])  p_oor[m] = 1;
        else if (seen[m][idx]) p_dup[m] = 1;
        else                   seen[m][idx] = 1;
      end
      if (fire && last) begin
        fmap = '0;
        for (int b = 0; b < 16; b++) fmap[b] = seen[m][b];
        e_map[m] = fmap;
        e_cnt[m] = $countones(fmap);
        e_dup[m] = p_dup[m];
        e_oor[m] = p_oor[m];
      end
      if ((fire && last) || c) begin
        for (int b = 0; b < 16; b++) seen[m][b] = 0;
        p_dup[m] = 0; p_oor[m] = 0;
      end
    end
    if (fire && last) e_vld = 1;
    @(negedge clk);
    check_outputs(tag, e_vld);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag, 1'b1);
    chk({tag, ".rdy16"}, 32'(rdy16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 0; in_vld = 1; in_idx = 4'd3; in_last = 0; out_rdy = 1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.rdy16", 32'(rdy16), 32'd0);
    chk("reset.rdy12", 32'(rdy12), 32'd0);
    chk("reset.map16", 32'(map16), 32'h0);
    check_outputs("reset", 1'b1);
    rst_n = 1'b1;

    // Basic frame: 3, 0, 15(last)
    cycle("basic0", 1, 3, 0, 1, 0);
    cycle("basic1", 1, 0, 0, 1, 0);
    cycle("basic2", 1, 15, 1, 1, 0);
    chk("basic.map_const", 32'(map16), 32'h8009);
    chk("basic.cnt_const", 32'(cnt16), 32'd3);
    cycle("basic_drop", 0, 0, 0, 1, 0);

    // Duplicates, then flags must not leak into the next frame
    cycle("dup0", 1, 5, 0, 1, 0);
    cycle("dup1", 1, 5, 0, 1, 0);
    cycle("dup2", 1, 5, 1, 1, 0);
    chk("dup.flag_const", 32'(dup16), 32'd1);
    cycle("nodup", 1, 2, 1, 1, 0);
    chk("nodup.flag_const", 32'(dup16), 32'd0);
    cycle("idle0", 0, 0, 0, 1, 0);

    // Back-pressure then back-to-back retire/accept
    cycle("bpA", 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle("bp_hold", 1, 7, 1, 0, 0);
    chk("bp.map_const", 32'(map16), 32'h0002);
    cycle("b2b", 1, 7, 1, 1, 0);
    chk("b2b.map_const", 32'(map16), 32'h0080);
    cycle("b2b_drop", 0, 0, 0, 1, 0);

    // Out-of-range on the 12-wide instance
    cycle("oor0", 1, 13, 0, 1, 0);
    cycle("oor1", 1, 11, 1, 1, 0);
    chk("oor.map_const", 32'(map12), 32'h800);
    chk("oor.flag_const", 32'(oor12), 32'd1);
    cycle("idle1", 0, 0, 0, 1, 0);

    // Abort with clr mid-frame
    cycle("clr0", 1, 4, 0, 1, 0);
    cycle("clr1", 1, 6, 0, 1, 0);
    cycle("clr2", 1, 9, 1, 1, 1);
    cycle("clr3", 1, 9, 1, 1, 0);
    chk("clr.map_const", 32'(map16), 32'h0200);
    cycle("idle2", 0, 0, 0, 0, 0);

    // Async reset mid-frame with a result pending
    cycle("rst0", 1, 4, 0, 0, 0);
    cycle("rst1", 1, 6, 0, 0, 0);
    reset_pulse("rst_mid");
    cycle("rst2", 0, 0, 0, 1, 0);
    cycle("rst3", 1, 9, 1, 1, 0);
    cycle("rst4", 0, 0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(3) != 0), int'($urandom_range(15)),
            ($urandom_range(3) == 0), ($urandom_range(2) != 0),
            ($urandom_range(15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
